// File: rtl/sextium_controller_gen.sv
// Sextium III control FSM. Fetches one memory word of packed 4-bit opcodes and
// decodes it slot by slot, driving the datapath mux selects and write strobes.
//
// Memory handshake: a read or write is requested by holding mem_read or
// mem_write together with its address select. The transfer completes in the
// cycle mem_ready is high, and every strobe and select stays constant until
// then. The slot index does not advance while a transfer is outstanding.
module sextium_controller_gen #(
  parameter int INSNS_PER_WORD = 4,
  parameter int SLOT_W         = $clog2(INSNS_PER_WORD),
  parameter int DIV_LATENCY    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        insn,
  input  logic              accz,
  input  logic              accn,
  input  logic              iobusy,
  input  logic              mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              pc_write,
  output logic              acc_write,
  output logic              seladdr,
  output logic [1:0]        selacc,
  output logic              selswap,
  output logic              doswap,
  output logic              selpc1,
  output logic              selpc2,
  output logic [1:0]        aluinsn,
  output logic [SLOT_W-1:0] curinsn,
  output logic              runio,
  output logic              diven,
  output logic              illegal,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    IOWAIT  = 2'd2,
    DIVWAIT = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_SYSCALL = 4'd1;
  localparam logic [3:0] OP_LOAD    = 4'd2;
  localparam logic [3:0] OP_STORE   = 4'd3;
  localparam logic [3:0] OP_SWAPA   = 4'd4;
  localparam logic [3:0] OP_SWAPD   = 4'd5;
  localparam logic [3:0] OP_BRANCHZ = 4'd6;
  localparam logic [3:0] OP_BRANCHN = 4'd7;
  localparam logic [3:0] OP_JUMP    = 4'd8;
  localparam logic [3:0] OP_CONST   = 4'd9;
  localparam logic [3:0] OP_ADD     = 4'd10;
  localparam logic [3:0] OP_SUB     = 4'd11;
  localparam logic [3:0] OP_MUL     = 4'd12;
  localparam logic [3:0] OP_DIV     = 4'd13;

  localparam logic [1:0] ACC_MEM  = 2'd0;
  localparam logic [1:0] ACC_IO   = 2'd1;
  localparam logic [1:0] ACC_SWAP = 2'd2;
  localparam logic [1:0] ACC_ALU  = 2'd3;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(INSNS_PER_WORD - 1);
  localparam logic [3:0]        DIV_LOAD  = 4'(DIV_LATENCY - 1);

  state_t            state, state_n;
  logic [SLOT_W-1:0] slot, slot_n;
  logic [3:0]        div_cnt, div_cnt_n;
  logic              advance;

  // State, slot index and divider countdown registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      slot    <= '0;
      div_cnt <= 4'd0;
    end else begin
      state   <= state_n;
      slot    <= slot_n;
      div_cnt <= div_cnt_n;
    end
  end

  // Next-state and output decode. Everything stays at 0 while reset is high.
  always_comb begin
    state_n   = state;
    slot_n    = slot;
    div_cnt_n = div_cnt;
    advance   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    acc_write = 1'b0;
    seladdr   = 1'b0;
    selacc    = ACC_MEM;
    selswap   = 1'b0;
    doswap    = 1'b0;
    selpc1    = 1'b0;
    selpc2    = 1'b0;
    aluinsn   = 2'd0;
    runio     = 1'b0;
    diven     = 1'b0;
    illegal   = 1'b0;

    if (!reset) begin
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          seladdr  = 1'b0;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            selpc1   = 1'b0;
            slot_n   = '0;
            state_n  = DECODE;
          end
        end

        DECODE: begin
          case (insn)
            OP_NOP: advance = 1'b1;
            OP_SYSCALL: begin
              runio   = 1'b1;
              selacc  = ACC_IO;
              state_n = IOWAIT;
            end
            OP_LOAD: begin
              mem_read  = 1'b1;
              seladdr   = 1'b1;
              selacc    = ACC_MEM;
              acc_write = mem_ready;
              advance   = mem_ready;
            end
            OP_STORE: begin
              mem_write = 1'b1;
              seladdr   = 1'b1;
              advance   = mem_ready;
            end
            OP_SWAPA, OP_SWAPD: begin
              doswap    = 1'b1;
              selswap   = (insn == OP_SWAPD);
              selacc    = ACC_SWAP;
              acc_write = 1'b1;
              advance   = 1'b1;
            end
            OP_BRANCHZ, OP_BRANCHN: begin
              if ((insn == OP_BRANCHZ) ? accz : accn) begin
                pc_write = 1'b1;
                selpc1   = 1'b1;
                selpc2   = 1'b0;
                slot_n   = '0;
                state_n  = FETCH;
              end else begin
                advance = 1'b1;
              end
            end
            OP_JUMP: begin
              pc_write = 1'b1;
              selpc1   = 1'b1;
              selpc2   = 1'b1;
              slot_n   = '0;
              state_n  = FETCH;
            end
            OP_CONST: begin
              mem_read  = 1'b1;
              seladdr   = 1'b0;
              selacc    = ACC_MEM;
              acc_write = mem_ready;
              pc_write  = mem_ready;
              selpc1    = 1'b0;
              advance   = mem_ready;
            end
            OP_ADD, OP_SUB, OP_MUL: begin
              selacc    = ACC_ALU;
              aluinsn   = insn[1:0] - 2'd2;
              acc_write = 1'b1;
              advance   = 1'b1;
            end
            OP_DIV: begin
              aluinsn   = 2'd3;
              selacc    = ACC_ALU;
              diven     = 1'b1;
              div_cnt_n = DIV_LOAD;
              state_n   = DIVWAIT;
            end
            default: begin
              illegal = 1'b1;
              advance = 1'b1;
            end
          endcase
        end

        IOWAIT: begin
          selacc = ACC_IO;
          runio  = iobusy;
          if (!iobusy) begin
            acc_write = 1'b1;
            advance   = 1'b1;
          end
        end

        DIVWAIT: begin
          aluinsn = 2'd3;
          selacc  = ACC_ALU;
          diven   = 1'b1;
          if (div_cnt == 4'd0) begin
            acc_write = 1'b1;
            advance   = 1'b1;
          end else begin
            div_cnt_n = div_cnt - 4'd1;
          end
        end

        default: state_n = FETCH;
      endcase

      // Generic slot advance; the wrap to slot 0 is explicit.
      if (advance) begin
        if (slot == LAST_SLOT) begin
          slot_n  = '0;
          state_n = FETCH;
        end else begin
          slot_n  = slot + SLOT_W'(1);
          state_n = DECODE;
        end
      end
    end
  end

  assign curinsn   = reset ? '0 : slot;
  assign state_dbg = reset ? 2'd0 : state;

endmodule

// File: tb/tb_sextium_controller_gen.sv
// Directed bench for sextium_controller_gen: a 4-slot instance with a 5-cycle
// divider, and a 2-slot instance for the illegal-opcode case. A tiny IR model
// feeds insn from the fetched word using curinsn.
module tb_sextium_controller_gen;

  logic        clock = 1'b0;
  logic        reset, accz, accn, iobusy, mem_ready;
  logic [15:0] mem_word, ir;
  logic [3:0]  insn;
  logic        mem_read, mem_write, ir_write, pc_write, acc_write, seladdr;
  logic [1:0]  selacc, aluinsn, state_dbg;
  logic        selswap, doswap, selpc1, selpc2, runio, diven, illegal;
  logic [1:0]  curinsn;

  logic        b_reset, b_accz, b_accn, b_iobusy, b_mem_ready;
  logic [7:0]  b_mem_word, b_ir;
  logic [3:0]  b_insn;
  logic        b_mem_read, b_mem_write, b_ir_write, b_pc_write, b_acc_write, b_seladdr;
  logic [1:0]  b_selacc, b_aluinsn, b_state_dbg;
  logic        b_selswap, b_doswap, b_selpc1, b_selpc2, b_runio, b_diven, b_illegal;
  logic        b_curinsn;

  int checks   = 0;
  int failures = 0;
  int cnt;

  // Clock: 10 time-unit period.
  always #5 clock = ~clock;

  sextium_controller_gen #(.INSNS_PER_WORD(4), .DIV_LATENCY(5)) u_dut (
    .clock(clock), .reset(reset), .insn(insn), .accz(accz), .accn(accn),
    .iobusy(iobusy), .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .acc_write(acc_write), .seladdr(seladdr), .selacc(selacc),
    .selswap(selswap), .doswap(doswap), .selpc1(selpc1), .selpc2(selpc2),
    .aluinsn(aluinsn), .curinsn(curinsn), .runio(runio), .diven(diven),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  sextium_controller_gen #(.INSNS_PER_WORD(2)) u_dut2 (
    .clock(clock), .reset(b_reset), .insn(b_insn), .accz(b_accz), .accn(b_accn),
    .iobusy(b_iobusy), .mem_ready(b_mem_ready), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .ir_write(b_ir_write), .pc_write(b_pc_write),
    .acc_write(b_acc_write), .seladdr(b_seladdr), .selacc(b_selacc),
    .selswap(b_selswap), .doswap(b_doswap), .selpc1(b_selpc1), .selpc2(b_selpc2),
    .aluinsn(b_aluinsn), .curinsn(b_curinsn), .runio(b_runio), .diven(b_diven),
    .illegal(b_illegal), .state_dbg(b_state_dbg)
  );

  // IR model: loads the memory word on ir_write, slot picked by curinsn.
  always_ff @(posedge clock) begin
    if (ir_write) ir <= mem_word;
    if (b_ir_write) b_ir <= b_mem_word;
  end
  assign insn   = ir[int'(curinsn)*4 +: 4];
  assign b_insn = b_ir[int'(b_curinsn)*4 +: 4];

  wire [20:0] all_out = {mem_read, mem_write, ir_write, pc_write, acc_write,
                         seladdr, selacc, selswap, doswap, selpc1, selpc2,
                         aluinsn, curinsn, runio, diven, illegal, state_dbg};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Runs until FETCH (bounded), then supplies the word with mem_ready high.
  task automatic fetch_word(input logic [15:0] w);
    for (int i = 0; i < 40 && state_dbg != 2'd0; i++) begin
      tick(); #1;
    end
    chk("fetch_reached", state_dbg, 2'd0);
    mem_word  = w;
    mem_ready = 1'b1;
    #1;
    chk("fetch_ir_write", ir_write, 1'b1);
  endtask

  initial begin
    reset = 1'b1; accz = 1'b0; accn = 1'b0; iobusy = 1'b0; mem_ready = 1'b1;
    mem_word = 16'h0000;
    b_reset = 1'b1; b_accz = 1'b0; b_accn = 1'b0; b_iobusy = 1'b0;
    b_mem_ready = 1'b1; b_mem_word = 8'hF0;

    // Reset: every output low.
    tick(); #1; chk("reset_zero_a", all_out, 0);
    tick(); #1; chk("reset_zero_b", all_out, 0);

    // Four NOPs: FETCH then slots 0..3, period of 5 cycles.
    tick(); reset = 1'b0; #1;
    chk("nop_fetch_state", state_dbg, 2'd0);
    chk("nop_fetch_pcw", pc_write, 1'b1);
    chk("nop_fetch_read", mem_read, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      chk("nop_curinsn", curinsn, (k == 5) ? 2'd0 : 2'(k - 1));
      chk("nop_pcw", pc_write, (k == 5) ? 1'b1 : 1'b0);
      chk("nop_state", state_dbg, (k == 5) ? 2'd0 : 2'd1);
    end

    // LOAD with three wait states.
    fetch_word(16'h0002);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); mem_ready = (k == 3); #1;
      chk("load_read", mem_read, 1'b1);
      chk("load_seladdr", seladdr, 1'b1);
      chk("load_curinsn", curinsn, 2'd0);
      chk("load_accw", acc_write, (k == 3) ? 1'b1 : 1'b0);
      cnt += acc_write;
    end
    chk("load_accw_count", cnt, 1);
    tick(); #1;
    chk("load_next_slot", curinsn, 2'd1);
    chk("load_read_off", mem_read, 1'b0);

    // DIV with a 5-cycle divider: 6 cycles of diven, single ACC write.
    fetch_word(16'h000D);
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      chk("div_en", diven, 1'b1);
      chk("div_alu", {aluinsn, selacc}, 4'hF);
      chk("div_accw", acc_write, (k == 5) ? 1'b1 : 1'b0);
      chk("div_curinsn", curinsn, 2'd0);
    end
    tick(); #1;
    chk("div_done_en", diven, 1'b0);
    chk("div_done_slot", curinsn, 2'd1);

    // BRANCHZ in slot 1, taken.
    fetch_word(16'h0060);
    tick(); #1; chk("bz_slot0", curinsn, 2'd0);
    tick(); accz = 1'b1; #1;
    chk("bz_t_slot", curinsn, 2'd1);
    chk("bz_t_pc", {pc_write, selpc1, selpc2}, 3'b110);
    tick(); accz = 1'b0; #1;
    chk("bz_t_fetch", state_dbg, 2'd0);
    chk("bz_t_cur0", curinsn, 2'd0);

    // BRANCHZ in slot 1, not taken.
    fetch_word(16'h0060);
    tick(); #1;
    tick(); #1;
    chk("bz_nt_pcw", pc_write, 1'b0);
    tick(); #1;
    chk("bz_nt_slot2", curinsn, 2'd2);
    chk("bz_nt_state", state_dbg, 2'd1);

    // JUMP in the last slot.
    fetch_word(16'h8000);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
    end
    chk("jump_slot", curinsn, 2'd3);
    chk("jump_pc", {pc_write, selpc1, selpc2}, 3'b111);
    tick(); #1;
    chk("jump_fetch", state_dbg, 2'd0);
    chk("jump_fetch_pc1", {pc_write, selpc1}, 2'b10);

    // SYSCALL with the IO unit busy.
    fetch_word(16'h0001);
    cnt = 0;
    tick(); iobusy = 1'b1; #1;
    chk("sys_decode", {runio, selacc}, 3'b101);
    cnt += runio;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk("sys_wait_state", state_dbg, 2'd2);
      chk("sys_wait_accw", acc_write, 1'b0);
      cnt += runio;
    end
    tick(); iobusy = 1'b0; #1;
    chk("sys_release", {runio, acc_write, selacc}, 4'b0101);
    chk("sys_runio_count", cnt, 5);
    tick(); #1;
    chk("sys_next_slot", curinsn, 2'd1);

    // ADD, SUB, MUL, SWAPD.
    fetch_word(16'h5CBA);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("alu_op", {aluinsn, selacc, acc_write}, {2'(k), 2'd3, 1'b1});
    end
    tick(); #1;
    chk("swapd", {doswap, selswap, selacc, acc_write}, 5'b11101);

    // SWAPA, CONST, STORE.
    fetch_word(16'h0394);
    tick(); #1;
    chk("swapa", {doswap, selswap, selacc, acc_write}, 5'b10101);
    tick(); #1;
    chk("const", {mem_read, seladdr, acc_write, pc_write, selpc1}, 5'b10110);
    tick(); #1;
    chk("store", {mem_write, mem_read, seladdr, acc_write}, 4'b1010);

    // Reset in the middle of DIVWAIT.
    fetch_word(16'h000D);
    tick(); #1; chk("rdiv_decode", diven, 1'b1);
    tick(); #1; chk("rdiv_wait", state_dbg, 2'd3);
    tick(); reset = 1'b1; #1; chk("rdiv_zero_a", all_out, 0);
    tick(); #1; chk("rdiv_zero_b", all_out, 0);
    tick(); reset = 1'b0; #1;
    chk("rdiv_fetch", {state_dbg, mem_read, diven}, 4'b0010);

    // Two-slot instance: opcode 15 in slot 1.
    tick(); b_reset = 1'b0; #1;
    chk("ill_fetch", b_ir_write, 1'b1);
    tick(); #1;
    chk("ill_slot0", {b_curinsn, b_illegal}, 2'b00);
    tick(); #1;
    chk("ill_slot1", {b_curinsn, b_illegal}, 2'b11);
    tick(); #1;
    chk("ill_refetch", {b_state_dbg, b_illegal, b_mem_read, b_curinsn}, 5'b00010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
